// File: rtl/iotdf_pkg.sv
// Shared constants, state encoding and function-select decode for the IOTDF
// byte-stream controller.
package iotdf_pkg;

  localparam int WORD_W          = 128;
  localparam int BYTE_W          = 8;
  localparam int WORDS_PER_ROUND = 8;
  localparam int N_ROUNDS_DEF    = 12;
  localparam int CNT_CYCLE_W     = 4;
  localparam int CNT_DATA_W      = 3;
  localparam int ROUND_W         = 8;
  localparam int FN_W            = 7;

  localparam logic [2:0] FN_NONE = 3'd0;
  localparam logic [2:0] FN_1    = 3'd1;
  localparam logic [2:0] FN_2    = 3'd2;
  localparam logic [2:0] FN_3    = 3'd3;
  localparam logic [2:0] FN_4    = 3'd4;
  localparam logic [2:0] FN_5    = 3'd5;
  localparam logic [2:0] FN_6    = 3'd6;
  localparam logic [2:0] FN_7    = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Code k (1..7) enables function block k-1; code 0 enables nothing.
  function automatic logic [FN_W-1:0] fn_decode(input logic [2:0] sel);
    logic [FN_W-1:0] one_hot;
    one_hot = '0;
    if (sel != FN_NONE) one_hot = 7'b1 << (sel - 3'd1);
    return one_hot;
  endfunction

endpackage

// File: rtl/iotdf_word_asm.sv
// Shifts accepted bytes MSB-first into a 128-bit word and tracks the byte slot;
// wrap flags the 16th byte of a word being accepted this cycle.
module iotdf_word_asm
  import iotdf_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   accept,
  input  logic [BYTE_W-1:0]      byte_in,
  output logic [WORD_W-1:0]      data,
  output logic [CNT_CYCLE_W-1:0] cnt_cycle,
  output logic                   wrap
);

  logic [WORD_W-1:0]      data_q, data_d;
  logic [CNT_CYCLE_W-1:0] cnt_cycle_q, cnt_cycle_d;

  always_comb begin
    data_d      = data_q;
    cnt_cycle_d = cnt_cycle_q;
    if (accept) begin
      data_d      = {data_q[WORD_W-BYTE_W-1:0], byte_in};
      // 4-bit counter rolls 15 -> 0 by itself
      cnt_cycle_d = cnt_cycle_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q      <= '0;
      cnt_cycle_q <= '0;
    end else begin
      data_q      <= data_d;
      cnt_cycle_q <= cnt_cycle_d;
    end
  end

  assign wrap      = accept && (cnt_cycle_q == 4'd15);
  assign data      = data_q;
  assign cnt_cycle = cnt_cycle_q;

endmodule

// File: rtl/iotdf_ctrl.sv
// IOTDF stream controller: IDLE/RUN/DONE sequencing, word and round counting,
// and the one-hot function enable latched once per run.
module iotdf_ctrl
  import iotdf_pkg::*;
#(
  parameter int N_ROUNDS = N_ROUNDS_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_en,
  input  logic [BYTE_W-1:0]      iot_in,
  input  logic [2:0]             fn_sel,
  output logic                   busy,
  output logic [WORD_W-1:0]      data,
  output logic [CNT_CYCLE_W-1:0] cnt_cycle,
  output logic [CNT_DATA_W-1:0]  cnt_data,
  output logic [FN_W-1:0]        fn_en,
  output logic                   word_vld,
  output logic                   round_done,
  output logic                   all_done
);

  state_t                state_q, state_d;
  logic [FN_W-1:0]       fn_en_q, fn_en_d;
  logic [CNT_DATA_W-1:0] cnt_data_q, cnt_data_d;
  logic [ROUND_W-1:0]    round_q, round_d;
  logic                  word_vld_q, word_vld_d;
  logic                  round_done_q, round_done_d;

  logic accept;
  logic wrap;
  logic word_last;
  logic round_last;

  assign accept     = (state_q == ST_RUN) && in_en;
  assign word_last  = wrap && (cnt_data_q == CNT_DATA_W'(WORDS_PER_ROUND - 1));
  assign round_last = word_last && (round_q == ROUND_W'(N_ROUNDS - 1));

  iotdf_word_asm u_word_asm (
    .clk       (clk),
    .rst       (rst),
    .accept    (accept),
    .byte_in   (iot_in),
    .data      (data),
    .cnt_cycle (cnt_cycle),
    .wrap      (wrap)
  );

  always_comb begin
    state_d      = state_q;
    fn_en_d      = fn_en_q;
    cnt_data_d   = cnt_data_q;
    round_d      = round_q;
    word_vld_d   = wrap;
    round_done_d = word_last;
    case (state_q)
      ST_IDLE: begin
        fn_en_d = fn_decode(fn_sel);
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (wrap) cnt_data_d = cnt_data_q + 3'd1;
        // Last word of the last round: all three counters land on 0 together
        if (word_last) round_d = round_last ? '0 : round_q + 8'd1;
        if (round_last) state_d = ST_DONE;
      end
      ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      fn_en_q      <= '0;
      cnt_data_q   <= '0;
      round_q      <= '0;
      word_vld_q   <= 1'b0;
      round_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fn_en_q      <= fn_en_d;
      cnt_data_q   <= cnt_data_d;
      round_q      <= round_d;
      word_vld_q   <= word_vld_d;
      round_done_q <= round_done_d;
    end
  end

  assign busy       = (state_q != ST_RUN);
  assign all_done   = (state_q == ST_DONE);
  assign cnt_data   = cnt_data_q;
  assign fn_en      = fn_en_q;
  assign word_vld   = word_vld_q;
  assign round_done = round_done_q;

endmodule

// File: tb/tb_iotdf_ctrl.sv
// Directed bench for iotdf_ctrl with N_ROUNDS=2 (256 bytes per run).
module tb_iotdf_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_en;
  logic [7:0]   iot_in;
  logic [2:0]   fn_sel;
  logic         busy;
  logic [127:0] data;
  logic [3:0]   cnt_cycle;
  logic [2:0]   cnt_data;
  logic [6:0]   fn_en;
  logic         word_vld;
  logic         round_done;
  logic         all_done;

  int vectors    = 0;
  int miscompares = 0;

  iotdf_ctrl #(.N_ROUNDS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_en      (in_en),
    .iot_in     (iot_in),
    .fn_sel     (fn_sel),
    .busy       (busy),
    .data       (data),
    .cnt_cycle  (cnt_cycle),
    .cnt_data   (cnt_data),
    .fn_en      (fn_en),
    .word_vld   (word_vld),
    .round_done (round_done),
    .all_done   (all_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: sim time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reset for two cycles, then let IDLE latch sel and move to RUN.
  task automatic start(input logic [2:0] sel);
    rst = 1'b1; in_en = 1'b0; iot_in = 8'h00; fn_sel = sel;
    tick; tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_en = 1'b1; iot_in = 8'hAA; fn_sel = 3'd6;
    tick; tick;
    vectors++;
    if (busy !== 1'b1 || data !== 128'h0 || cnt_cycle !== 4'd0 || cnt_data !== 3'd0 ||
        fn_en !== 7'd0 || word_vld !== 1'b0 || round_done !== 1'b0 || all_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b data=%h cc=%0d cd=%0d fn=%b wv=%b rd=%b ad=%b, required 1/0/0/0/0/0/0/0",
               busy, data, cnt_cycle, cnt_data, fn_en, word_vld, round_done, all_done);
    end
    // in_en stays high through IDLE and must be ignored there
    rst = 1'b0;
    tick;
    vectors++;
    if (busy !== 1'b0 || fn_en !== 7'b0100000 || cnt_cycle !== 4'd0) begin
      miscompares++;
      $display("FAIL idle_to_run: busy=%b fn_en=%b cc=%0d, required busy=0 fn_en=0100000 cc=0",
               busy, fn_en, cnt_cycle);
    end
    in_en = 1'b0;
  endtask

  task automatic test_back_to_back;
    for (int b = 0; b < 16; b++) begin
      in_en = 1'b1; iot_in = 8'(b);
      tick;
      vectors++;
      if (cnt_cycle !== 4'((b + 1) % 16) || word_vld !== (b == 15)) begin
        miscompares++;
        $display("FAIL b2b_byte%0d: cc=%0d wv=%b, required cc=%0d wv=%b",
                 b, cnt_cycle, word_vld, (b + 1) % 16, (b == 15));
      end
    end
    in_en = 1'b0;
    vectors++;
    if (data !== 128'h000102030405060708090A0B0C0D0E0F || cnt_data !== 3'd1 || fn_en !== 7'b0100000) begin
      miscompares++;
      $display("FAIL b2b_word: data=%h cd=%0d fn=%b, required data=000102030405060708090a0b0c0d0e0f cd=1 fn=0100000",
               data, cnt_data, fn_en);
    end
    tick;
    vectors++;
    if (word_vld !== 1'b0 || data !== 128'h000102030405060708090A0B0C0D0E0F) begin
      miscompares++;
      $display("FAIL b2b_after: wv=%b data=%h, required wv=0 data held", word_vld, data);
    end
  endtask

  task automatic test_gaps;
    logic [127:0] exp_data;
    exp_data = '0;
    start(3'd6);
    for (int b = 0; b < 16; b++) begin
      in_en = 1'b1; iot_in = 8'(b);
      exp_data = {exp_data[119:0], 8'(b)};
      tick;
      vectors++;
      if (cnt_cycle !== 4'((b + 1) % 16) || word_vld !== (b == 15) || data !== exp_data) begin
        miscompares++;
        $display("FAIL gap_accept%0d: cc=%0d wv=%b data=%h, required cc=%0d wv=%b data=%h",
                 b, cnt_cycle, word_vld, data, (b + 1) % 16, (b == 15), exp_data);
      end
      in_en = 1'b0; iot_in = 8'hEE;
      tick;
      vectors++;
      if (cnt_cycle !== 4'((b + 1) % 16) || word_vld !== 1'b0 || data !== exp_data ||
          cnt_data !== ((b == 15) ? 3'd1 : 3'd0)) begin
        miscompares++;
        $display("FAIL gap_hold%0d: cc=%0d cd=%0d wv=%b data=%h, required cc=%0d cd=%0d wv=0 data=%h",
                 b, cnt_cycle, cnt_data, word_vld, data, (b + 1) % 16, (b == 15) ? 1 : 0, exp_data);
      end
    end
  endtask

  task automatic test_rounds;
    logic exp_vld, exp_rd, exp_done;
    start(3'd2);
    for (int k = 0; k < 256; k++) begin
      in_en = 1'b1; iot_in = k[7:0];
      tick;
      exp_vld  = (k % 16 == 15);
      exp_rd   = (k % 128 == 127);
      exp_done = (k == 255);
      vectors++;
      if (word_vld !== exp_vld || round_done !== exp_rd || all_done !== exp_done ||
          busy !== exp_done || cnt_data !== 3'(((k + 1) / 16) % 8)) begin
        miscompares++;
        $display("FAIL round_byte%0d: wv=%b rd=%b ad=%b busy=%b cd=%0d, required %b/%b/%b/%b/%0d",
                 k, word_vld, round_done, all_done, busy, cnt_data,
                 exp_vld, exp_rd, exp_done, exp_done, ((k + 1) / 16) % 8);
      end
    end
    vectors++;
    if (data !== 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF || cnt_cycle !== 4'd0) begin
      miscompares++;
      $display("FAIL round_final_word: data=%h cc=%0d, required f0f1..feff cc=0", data, cnt_cycle);
    end
    iot_in = 8'h55;
    tick;
    vectors++;
    if (data !== 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF || cnt_cycle !== 4'd0 || cnt_data !== 3'd0 ||
        word_vld !== 1'b0 || round_done !== 1'b0 || busy !== 1'b1 || all_done !== 1'b1 ||
        fn_en !== 7'b0000010) begin
      miscompares++;
      $display("FAIL done_ignore: data=%h cc=%0d cd=%0d wv=%b rd=%b busy=%b ad=%b fn=%b, required data held, 0,0,0,0,1,1,0000010",
               data, cnt_cycle, cnt_data, word_vld, round_done, busy, all_done, fn_en);
    end
    in_en = 1'b0;
  endtask

  task automatic test_reset_mid;
    start(3'd6);
    for (int k = 0; k < 57; k++) begin
      in_en = 1'b1; iot_in = 8'(k + 1);
      tick;
    end
    vectors++;
    if (cnt_data !== 3'd3 || cnt_cycle !== 4'd9) begin
      miscompares++;
      $display("FAIL mid_position: cd=%0d cc=%0d, required cd=3 cc=9", cnt_data, cnt_cycle);
    end
    rst = 1'b1;
    tick;
    vectors++;
    if (busy !== 1'b1 || data !== 128'h0 || cnt_cycle !== 4'd0 || cnt_data !== 3'd0 ||
        fn_en !== 7'd0 || word_vld !== 1'b0 || round_done !== 1'b0 || all_done !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_state: busy=%b data=%h cc=%0d cd=%0d fn=%b wv=%b rd=%b ad=%b, required 1/0/0/0/0/0/0/0",
               busy, data, cnt_cycle, cnt_data, fn_en, word_vld, round_done, all_done);
    end
    rst = 1'b0; in_en = 1'b0;
    tick;
    for (int b = 0; b < 16; b++) begin
      in_en = 1'b1; iot_in = 8'hA0 + 8'(b);
      tick;
      vectors++;
      if (word_vld !== (b == 15) || round_done !== 1'b0 || cnt_data !== ((b == 15) ? 3'd1 : 3'd0)) begin
        miscompares++;
        $display("FAIL restart_byte%0d: wv=%b rd=%b cd=%0d, required wv=%b rd=0 cd=%0d",
                 b, word_vld, round_done, cnt_data, (b == 15), (b == 15) ? 1 : 0);
      end
    end
    in_en = 1'b0;
  endtask

  task automatic test_fn_sel;
    start(3'd0);
    fn_sel = 3'd3;
    for (int b = 0; b < 20; b++) begin
      in_en = b[0]; iot_in = 8'(b);
      tick;
      vectors++;
      if (fn_en !== 7'd0) begin
        miscompares++;
        $display("FAIL fn_none_cycle%0d: fn_en=%b, required 0000000", b, fn_en);
      end
    end
    in_en = 1'b0;
  endtask

  task automatic test_fn_decode;
    logic [6:0] tbl [1:7];
    tbl[1] = 7'b0000001; tbl[2] = 7'b0000010; tbl[3] = 7'b0000100; tbl[4] = 7'b0001000;
    tbl[5] = 7'b0010000; tbl[6] = 7'b0100000; tbl[7] = 7'b1000000;
    for (int s = 1; s <= 7; s++) begin
      start(3'(s));
      fn_sel = 3'd0;
      tick;
      vectors++;
      if (fn_en !== tbl[s]) begin
        miscompares++;
        $display("FAIL fn_decode_sel%0d: fn_en=%b, required %b", s, fn_en, tbl[s]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_en = 1'b0; iot_in = 8'h00; fn_sel = 3'd0;
    test_reset;
    test_back_to_back;
    test_gaps;
    test_rounds;
    test_reset_mid;
    test_fn_sel;
    test_fn_decode;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
